// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 16;
    localparam int BURST_W   = 10;
    localparam int MAX_BURST = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // A zero-length request still moves one word; anything longer than the
    // controller's page-sized maximum is cut down to that maximum.
    function automatic logic [BURST_W-1:0] clamp_burst(input logic [BURST_W-1:0] b);
        logic [BURST_W-1:0] r;
        if (b == '0) begin
            r = BURST_W'(1);
        end else if (b > BURST_W'(MAX_BURST)) begin
            r = BURST_W'(MAX_BURST);
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: the first requester found when scanning
// upward from ptr (wrapping modulo NUM_PORTS) wins.
module sdram_rr_pick #(
    parameter int NUM_PORTS = 3,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] win_onehot,
    output logic [PTR_W-1:0]     win_idx,
    output logic                 win_valid
);

    // cand_idx[k] is the port index sitting k places after the pointer.
    logic [PTR_W-1:0]     cand_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] cand_req;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
        logic [PTR_W:0] sum;
        assign sum          = {1'b0, ptr} + (PTR_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (PTR_W+1)'(NUM_PORTS))
                            ? PTR_W'(sum - (PTR_W+1)'(NUM_PORTS))
                            : sum[PTR_W-1:0];
        assign cand_req[gi] = req[cand_idx[gi]];
        assign win_onehot[gi] = win_valid && (win_idx == PTR_W'(gi));
    end

    // Scan from the farthest candidate down so the nearest one overrides.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one sdram_controller command port.
// One transaction at a time: IDLE (pick) -> XFER (beats) -> DONE (pulse).
// Build option SDRAM_ARB_PORT0_PRIO_EN: port 0 gets strict priority and the
// remaining ports round-robin among themselves.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int RR_INIT   = 1
) (
    input  logic                          clk,
    input  logic                          sys_rst_n,
    input  logic [NUM_PORTS-1:0]          port_req,
    input  logic [NUM_PORTS-1:0]          port_we,
    input  logic [ADDR_W*NUM_PORTS-1:0]   port_addr,
    input  logic [BURST_W*NUM_PORTS-1:0]  port_burst,
    input  logic [DATA_W*NUM_PORTS-1:0]   port_wdata,
    output logic [NUM_PORTS-1:0]          port_wdata_pop,
    output logic [DATA_W-1:0]             port_rdata,
    output logic [NUM_PORTS-1:0]          port_rdata_valid,
    output logic [NUM_PORTS-1:0]          port_grant,
    output logic [NUM_PORTS-1:0]          port_done,
    input  logic                          sdram_init_done,
    output logic                          sdram_wr_req,
    output logic                          sdram_rd_req,
    input  logic                          sdram_wr_ack,
    input  logic                          sdram_rd_ack,
    output logic [ADDR_W-1:0]             sdram_wr_addr,
    output logic [ADDR_W-1:0]             sdram_rd_addr,
    output logic [BURST_W-1:0]            sdram_wr_burst,
    output logic [BURST_W-1:0]            sdram_rd_burst,
    output logic [DATA_W-1:0]             sdram_din,
    input  logic [DATA_W-1:0]             sdram_dout
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    // Per-port views of the packed request buses.
    logic [ADDR_W-1:0]  addr_arr  [NUM_PORTS];
    logic [BURST_W-1:0] burst_arr [NUM_PORTS];
    logic [DATA_W-1:0]  wdata_arr [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign addr_arr[gi]  = port_addr[gi*ADDR_W +: ADDR_W];
        assign burst_arr[gi] = port_burst[gi*BURST_W +: BURST_W];
        assign wdata_arr[gi] = port_wdata[gi*DATA_W +: DATA_W];
    end

    arb_state_t           state_reg, state_next;
    logic [NUM_PORTS-1:0] grant_reg, grant_next;
    logic [PTR_W-1:0]     gidx_reg, gidx_next;
    logic                 we_reg, we_next;
    logic [BURST_W-1:0]   burst_reg, burst_next;
    logic [BURST_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic                 wr_req_reg, wr_req_next;
    logic                 rd_req_reg, rd_req_next;
    logic [ADDR_W-1:0]    wr_addr_reg, wr_addr_next;
    logic [ADDR_W-1:0]    rd_addr_reg, rd_addr_next;
    logic [BURST_W-1:0]   wr_burst_reg, wr_burst_next;
    logic [BURST_W-1:0]   rd_burst_reg, rd_burst_next;

    // Winner selection.
    logic [NUM_PORTS-1:0] pick_req;
    logic [NUM_PORTS-1:0] rr_onehot;
    logic [PTR_W-1:0]     rr_idx;
    logic                 rr_valid;
    logic [NUM_PORTS-1:0] win_onehot;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_valid;
    logic [PTR_W-1:0]     ptr_inc;
    logic [PTR_W-1:0]     ptr_after;

    sdram_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req        (pick_req),
        .ptr        (rr_ptr_reg),
        .win_onehot (rr_onehot),
        .win_idx    (rr_idx),
        .win_valid  (rr_valid)
    );

    assign ptr_inc = (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + PTR_W'(1);

`ifdef SDRAM_ARB_PORT0_PRIO_EN
    // Video port pre-empts the rotation; the pointer only cycles over 1..N-1
    // and is left alone when port 0 wins.
    assign pick_req   = {port_req[NUM_PORTS-1:1], 1'b0};
    assign win_valid  = port_req[0] | rr_valid;
    assign win_idx    = port_req[0] ? '0 : rr_idx;
    assign win_onehot = port_req[0] ? NUM_PORTS'(1) : rr_onehot;
    assign ptr_after  = port_req[0] ? rr_ptr_reg
                      : ((ptr_inc == '0) ? PTR_W'(1) : ptr_inc);
`else
    assign pick_req   = port_req;
    assign win_valid  = rr_valid;
    assign win_idx    = rr_idx;
    assign win_onehot = rr_onehot;
    assign ptr_after  = ptr_inc;
`endif

    // Beat strobe for the direction in flight; the other direction is ignored.
    logic beat_ack;
    assign beat_ack = we_reg ? sdram_wr_ack : sdram_rd_ack;

    // State register.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and latched transaction fields.
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        gidx_next     = gidx_reg;
        we_next       = we_reg;
        burst_next    = burst_reg;
        count_next    = count_reg;
        rr_ptr_next   = rr_ptr_reg;
        wr_req_next   = wr_req_reg;
        rd_req_next   = rd_req_reg;
        wr_addr_next  = wr_addr_reg;
        rd_addr_next  = rd_addr_reg;
        wr_burst_next = wr_burst_reg;
        rd_burst_next = rd_burst_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sdram_init_done && win_valid) begin
                    state_next  = ST_XFER;
                    grant_next  = win_onehot;
                    gidx_next   = win_idx;
                    we_next     = port_we[win_idx];
                    burst_next  = clamp_burst(burst_arr[win_idx]);
                    count_next  = '0;
                    rr_ptr_next = ptr_after;
                    if (port_we[win_idx]) begin
                        wr_req_next   = 1'b1;
                        wr_addr_next  = addr_arr[win_idx];
                        wr_burst_next = clamp_burst(burst_arr[win_idx]);
                        rd_req_next   = 1'b0;
                        rd_addr_next  = '0;
                        rd_burst_next = '0;
                    end else begin
                        rd_req_next   = 1'b1;
                        rd_addr_next  = addr_arr[win_idx];
                        rd_burst_next = clamp_burst(burst_arr[win_idx]);
                        wr_req_next   = 1'b0;
                        wr_addr_next  = '0;
                        wr_burst_next = '0;
                    end
                end
            end
            ST_XFER: begin
                if (beat_ack) begin
                    count_next = count_reg + BURST_W'(1);
                    if (count_reg == burst_reg - BURST_W'(1)) begin
                        wr_req_next = 1'b0;
                        rd_req_next = 1'b0;
                        state_next  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers; a reset aborts any burst in progress.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            grant_reg    <= '0;
            gidx_reg     <= '0;
            we_reg       <= 1'b0;
            burst_reg    <= '0;
            count_reg    <= '0;
            rr_ptr_reg   <= PTR_W'(RR_INIT);
            wr_req_reg   <= 1'b0;
            rd_req_reg   <= 1'b0;
            wr_addr_reg  <= '0;
            rd_addr_reg  <= '0;
            wr_burst_reg <= '0;
            rd_burst_reg <= '0;
        end else begin
            grant_reg    <= grant_next;
            gidx_reg     <= gidx_next;
            we_reg       <= we_next;
            burst_reg    <= burst_next;
            count_reg    <= count_next;
            rr_ptr_reg   <= rr_ptr_next;
            wr_req_reg   <= wr_req_next;
            rd_req_reg   <= rd_req_next;
            wr_addr_reg  <= wr_addr_next;
            rd_addr_reg  <= rd_addr_next;
            wr_burst_reg <= wr_burst_next;
            rd_burst_reg <= rd_burst_next;
        end
    end

    // Beat routing is purely combinational so a pop or valid lines up with
    // the controller's ack in the same cycle.
    logic xfer_wr, xfer_rd;
    assign xfer_wr = (state_reg == ST_XFER) && we_reg;
    assign xfer_rd = (state_reg == ST_XFER) && !we_reg;

    assign port_wdata_pop   = (xfer_wr && sdram_wr_ack) ? grant_reg : '0;
    assign port_rdata_valid = (xfer_rd && sdram_rd_ack) ? grant_reg : '0;
    assign port_done        = (state_reg == ST_DONE) ? grant_reg : '0;
    assign port_grant       = grant_reg;
    assign sdram_din        = xfer_wr ? wdata_arr[gidx_reg] : '0;
    assign port_rdata       = xfer_rd ? sdram_dout : '0;

    assign sdram_wr_req   = wr_req_reg;
    assign sdram_rd_req   = rd_req_reg;
    assign sdram_wr_addr  = wr_addr_reg;
    assign sdram_rd_addr  = rd_addr_reg;
    assign sdram_wr_burst = wr_burst_reg;
    assign sdram_rd_burst = rd_burst_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a
// randomized phase, all checked cycle by cycle against a transaction model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int N       = 3;
    localparam int RR_INIT = 1;

    localparam int MODE_HOLD = 0;
    localparam int MODE_ALL  = 1;
    localparam int MODE_RAND = 2;

    logic            clk = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic [N-1:0]    port_req = '0;
    logic [N-1:0]    port_we = '0;
    logic [24*N-1:0] port_addr = '0;
    logic [10*N-1:0] port_burst = '0;
    logic [16*N-1:0] port_wdata = '0;
    logic [N-1:0]    port_wdata_pop;
    logic [15:0]     port_rdata;
    logic [N-1:0]    port_rdata_valid;
    logic [N-1:0]    port_grant;
    logic [N-1:0]    port_done;
    logic            sdram_init_done = 1'b0;
    logic            sdram_wr_req, sdram_rd_req;
    logic            sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
    logic [23:0]     sdram_wr_addr, sdram_rd_addr;
    logic [9:0]      sdram_wr_burst, sdram_rd_burst;
    logic [15:0]     sdram_din;
    logic [15:0]     sdram_dout = '0;

    sdram_port_arbiter #(.NUM_PORTS(N), .RR_INIT(RR_INIT)) dut (
        .clk              (clk),
        .sys_rst_n        (sys_rst_n),
        .port_req         (port_req),
        .port_we          (port_we),
        .port_addr        (port_addr),
        .port_burst       (port_burst),
        .port_wdata       (port_wdata),
        .port_wdata_pop   (port_wdata_pop),
        .port_rdata       (port_rdata),
        .port_rdata_valid (port_rdata_valid),
        .port_grant       (port_grant),
        .port_done        (port_done),
        .sdram_init_done  (sdram_init_done),
        .sdram_wr_req     (sdram_wr_req),
        .sdram_rd_req     (sdram_rd_req),
        .sdram_wr_ack     (sdram_wr_ack),
        .sdram_rd_ack     (sdram_rd_ack),
        .sdram_wr_addr    (sdram_wr_addr),
        .sdram_rd_addr    (sdram_rd_addr),
        .sdram_wr_burst   (sdram_wr_burst),
        .sdram_rd_burst   (sdram_rd_burst),
        .sdram_din        (sdram_din),
        .sdram_dout       (sdram_dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus controls shared with the main sequence.
    int req_mode = MODE_HOLD;
    int ack_mode = 1;
    bit rest [N];

    // Tallies observed on the DUT outputs.
    int pops [N];
    int valids [N];
    int dones [N];
    int grant_log [$];
    int txn = 0;

    // Transaction-level model: who owns the controller, how many beats remain.
    int          m_owner = -1;
    int          m_left = 0;
    int          m_burst = 0;
    int          m_ptr = RR_INIT;
    logic        m_we = 1'b0;
    logic [23:0] m_addr = '0;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef SDRAM_ARB_PORT0_PRIO_EN
        if (r[0]) return 0;
        for (int k = 0; k < N - 1; k++) begin
            int c;
            c = 1 + ((ptr - 1 + k) % (N - 1));
            if (r[c]) return c;
        end
        return -1;
`else
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (r[c]) return c;
        end
        return -1;
`endif
    endfunction

    // Requester and controller behaviour, driven just after each rising edge.
    initial begin : driver
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (port_done[i]) begin
                    port_req[i] = 1'b0;
                    rest[i] = 1'b1;
                end else if (req_mode == MODE_ALL) begin
                    if (rest[i]) rest[i] = 1'b0;
                    else port_req[i] = 1'b1;
                end else if (req_mode == MODE_RAND) begin
                    if (!port_req[i]) begin
                        if ($urandom_range(3) == 0) begin
                            port_req[i] = 1'b1;
                            port_we[i] = 1'($urandom);
                            port_addr[24*i +: 24] = 24'($urandom);
                            port_burst[10*i +: 10] = ($urandom_range(9) == 0) ? 10'd0
                                                   : 10'($urandom_range(12, 1));
                        end
                    end else if (port_grant[i] && $urandom_range(15) == 0) begin
                        port_req[i] = 1'b0;
                    end
                end
            end
            if (req_mode == MODE_RAND) sdram_init_done = ($urandom_range(31) != 0);
            port_wdata = 48'({$urandom, $urandom});
            sdram_dout = 16'($urandom);
            if (ack_mode == 1) begin
                sdram_wr_ack = sdram_wr_req;
                sdram_rd_ack = sdram_rd_req;
            end else begin
                sdram_wr_ack = sdram_wr_req ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
                sdram_rd_ack = sdram_rd_req ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
            end
        end
    end

    // Compare DUT against the model on every falling edge, then advance it.
    initial begin : compare_proc
        logic [N-1:0] e_oh;
        logic [N-1:0] prev_grant;
        logic         xf;
        int           w, b;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (!sys_rst_n) begin
                m_owner = -1;
                m_left = 0;
                m_ptr = RR_INIT;
                prev_grant = '0;
            end else begin
                e_oh = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
                xf = (m_owner >= 0) && (m_left > 0);
                check("grant", 32'(port_grant), 32'(e_oh));
                check("wr_req", 32'(sdram_wr_req), 32'(xf && m_we));
                check("rd_req", 32'(sdram_rd_req), 32'(xf && !m_we));
                check("done", 32'(port_done), 32'((m_owner >= 0 && m_left == 0) ? e_oh : '0));
                check("pop", 32'(port_wdata_pop), 32'((xf && m_we && sdram_wr_ack) ? e_oh : '0));
                check("valid", 32'(port_rdata_valid), 32'((xf && !m_we && sdram_rd_ack) ? e_oh : '0));
                if (xf && m_we) begin
                    check("wr_addr", 32'(sdram_wr_addr), 32'(m_addr));
                    check("wr_burst", 32'(sdram_wr_burst), 32'(m_burst));
                    check("rd_addr_idle", 32'(sdram_rd_addr), 32'(0));
                    check("din", 32'(sdram_din), 32'(port_wdata[16*m_owner +: 16]));
                end
                if (xf && !m_we) begin
                    check("rd_addr", 32'(sdram_rd_addr), 32'(m_addr));
                    check("rd_burst", 32'(sdram_rd_burst), 32'(m_burst));
                    check("wr_addr_idle", 32'(sdram_wr_addr), 32'(0));
                    if (sdram_rd_ack) check("rdata", 32'(port_rdata), 32'(sdram_dout));
                end
                for (int i = 0; i < N; i++) begin
                    pops[i] += int'(port_wdata_pop[i]);
                    valids[i] += int'(port_rdata_valid[i]);
                    dones[i] += int'(port_done[i]);
                    if (prev_grant == '0 && port_grant[i]) grant_log.push_back(i);
                end
                prev_grant = port_grant;

                if (m_owner < 0) begin
                    if (sdram_init_done && port_req != '0) begin
                        w = pick(port_req, m_ptr);
                        m_owner = w;
                        m_we = port_we[w];
                        m_addr = port_addr[24*w +: 24];
                        b = int'(port_burst[10*w +: 10]);
                        m_burst = (b == 0) ? 1 : ((b > 512) ? 512 : b);
                        m_left = m_burst;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
                        if (w != 0) m_ptr = (w == N - 1) ? 1 : w + 1;
`else
                        m_ptr = (w + 1) % N;
`endif
                    end
                end else if (m_left > 0) begin
                    if ((m_we && sdram_wr_ack) || (!m_we && sdram_rd_ack)) m_left--;
                end else begin
                    txn++;
                    $display("txn %0d: port %0d %s addr=0x%06h beats=%0d",
                             txn, m_owner, m_we ? "WR" : "RD", m_addr, m_burst);
                    m_owner = -1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_quiet(input string name, input int limit);
        for (int c = 0; c < limit; c++) begin
            tick(1);
            if (port_grant == '0 && port_req == '0) break;
        end
        check(name, 32'({port_grant, port_req}), 32'(0));
    endtask

    task automatic clear_tallies();
        for (int i = 0; i < N; i++) begin
            pops[i] = 0;
            valids[i] = 0;
            dones[i] = 0;
        end
        grant_log.delete();
    endtask

    task automatic set_port(input int p, input logic we, input logic [23:0] a, input logic [9:0] bl);
        port_we[p] = we;
        port_addr[24*p +: 24] = a;
        port_burst[10*p +: 10] = bl;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int exp_order [6];
        int cnt;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
        exp_order = '{0, 1, 0, 2, 0, 1};
`else
        exp_order = '{1, 2, 0, 1, 2, 0};
`endif
        // Reset values.
        tick(3);
        sys_rst_n = 1'b1;
        check("rst_grant", 32'(port_grant), 32'(0));
        check("rst_reqs", 32'({sdram_wr_req, sdram_rd_req}), 32'(0));
        check("rst_addr", 32'({sdram_wr_addr, sdram_rd_addr}), 32'(0));
        check("rst_burst", 32'({sdram_wr_burst, sdram_rd_burst}), 32'(0));

        // 1: nothing is granted before the controller finishes init.
        set_port(0, 1'b0, 24'h0A0000, 10'd4);
        set_port(1, 1'b0, 24'h123456, 10'd2);
        port_req = 3'b011;
        tick(20);
        check("init_hold_grant", 32'(port_grant), 32'(0));
        check("init_hold_req", 32'({sdram_wr_req, sdram_rd_req}), 32'(0));
        sdram_init_done = 1'b1;
        tick(1);
        check("init_first_grant", 32'(port_grant), 32'(3'b010));
        check("init_first_rdreq", 32'(sdram_rd_req), 32'(1));
        check("init_first_rdaddr", 32'(sdram_rd_addr), 32'(24'h123456));
        wait_quiet("s1_quiet", 100);

        // 2: port 2 write, 8 beats back to back.
        clear_tallies();
        set_port(2, 1'b1, 24'h000100, 10'd8);
        port_req[2] = 1'b1;
        wait_quiet("s2_quiet", 100);
        check("s2_pops", 32'(pops[2]), 32'(8));
        check("s2_done", 32'(dones[2]), 32'(1));

        // 3: all ports keep requesting 4-beat reads; pointer restarts at RR_INIT.
        sys_rst_n = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        clear_tallies();
        for (int i = 0; i < N; i++) begin
            set_port(i, 1'b0, 24'(32'h200000 + i * 32'h1000), 10'd4);
            rest[i] = 1'b0;
        end
        req_mode = MODE_ALL;
        for (int c = 0; c < 300 && grant_log.size() < 6; c++) tick(1);
        req_mode = MODE_HOLD;
        wait_quiet("s3_quiet", 200);
        check("s3_ngrants", 32'(grant_log.size() >= 6), 32'(1));
        for (int k = 0; k < 6; k++) begin
            if (k < grant_log.size()) check($sformatf("s3_order%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));
        end
        for (int i = 0; i < N; i++) begin
            cnt = 0;
            foreach (grant_log[k]) if (grant_log[k] == i) cnt++;
            check($sformatf("s3_valids%0d", i), 32'(valids[i]), 32'(4 * cnt));
        end

        // 5: burst 0 becomes one beat; 1023 is cut to 512.
        clear_tallies();
        set_port(1, 1'b0, 24'h00ABCD, 10'd0);
        port_req[1] = 1'b1;
        tick(1);
        check("s5_burst1", 32'(sdram_rd_burst), 32'(1));
        wait_quiet("s5a_quiet", 50);
        check("s5_valid1", 32'(valids[1]), 32'(1));
        check("s5_done1", 32'(dones[1]), 32'(1));
        clear_tallies();
        set_port(1, 1'b1, 24'h00F000, 10'd1023);
        port_req[1] = 1'b1;
        tick(1);
        check("s5_burst512", 32'(sdram_wr_burst), 32'(512));
        wait_quiet("s5b_quiet", 700);
        check("s5_pops512", 32'(pops[1]), 32'(512));
        check("s5_done512", 32'(dones[1]), 32'(1));

        // 6: asynchronous reset in the middle of a burst-8 write.
        sys_rst_n = 1'b0;
        tick(1);
        sys_rst_n = 1'b1;
        clear_tallies();
        set_port(2, 1'b1, 24'h000300, 10'd8);
        port_req[2] = 1'b1;
        for (int c = 0; c < 50 && pops[2] < 3; c++) tick(1);
        #1 sys_rst_n = 1'b0;
        #1;
        check("s6_grant", 32'(port_grant), 32'(0));
        check("s6_reqs", 32'({sdram_wr_req, sdram_rd_req}), 32'(0));
        check("s6_beats", 32'({port_wdata_pop, port_rdata_valid, port_done}), 32'(0));
        check("s6_addr", 32'({sdram_wr_addr, sdram_rd_addr}), 32'(0));
        check("s6_burst_din", 32'({sdram_wr_burst, sdram_rd_burst, sdram_din}), 32'(0));
        port_req = '0;
        set_port(1, 1'b0, 24'h000011, 10'd1);
        set_port(2, 1'b0, 24'h000022, 10'd1);
        tick(2);
        port_req = 3'b110;
        #1 sys_rst_n = 1'b1;
        tick(1);
        check("s6_ptr_after_rst", 32'(port_grant), 32'(3'b010));
        wait_quiet("s6_quiet", 100);

        // Randomized traffic with jittery acks and stray acks outside grants.
        ack_mode = 0;
        req_mode = MODE_RAND;
        tick(4000);
        req_mode = MODE_HOLD;
        sdram_init_done = 1'b1;
        wait_quiet("rand_quiet", 500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
